// File: rtl/example_sdiv_seq_21_14_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// Handshake: an operation is accepted on a rising clock edge where ap_start
// and ap_ready are both high; ap_ready is only ever high while the divider
// can take new operands. ap_done pulses for exactly one cycle, and quot, rem,
// div_zero and ovf are valid from that cycle until the next ap_done.
interface example_sdiv_seq_21_14_if #(
    parameter int DIVIDEND_W = 21,
    parameter int DIVISOR_W  = 14
);
    logic                  ap_start;
    logic [DIVIDEND_W-1:0] din0;
    logic [DIVISOR_W-1:0]  din1;
    logic                  ap_ready;
    logic                  ap_idle;
    logic                  ap_done;
    logic [DIVIDEND_W-1:0] quot;
    logic [DIVISOR_W-1:0]  rem;
    logic                  div_zero;
    logic                  ovf;

    modport master (
        output ap_start, din0, din1,
        input  ap_ready, ap_idle, ap_done, quot, rem, div_zero, ovf
    );

    modport slave (
        input  ap_start, din0, din1,
        output ap_ready, ap_idle, ap_done, quot, rem, div_zero, ovf
    );
endinterface

// File: rtl/example_sdiv_seq_21_14.sv
// Sequential signed divider, 21-bit dividend by 14-bit divisor, C semantics
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Restoring radix-2 on operand magnitudes, one quotient bit per cycle, with a
// fixed 22-cycle latency from accept to ap_done regardless of operand values.
module example_sdiv_seq_21_14 #(
    parameter int DIVIDEND_W = 21,
    parameter int DIVISOR_W  = 14
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    example_sdiv_seq_21_14_if.slave bus,
    output logic [1:0]             state_dbg
);
    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] DVD_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   accept;
    logic   last;

    // Magnitude of the dividend; quotient bits shift in at the LSB as dividend
    // bits leave at the MSB. A 21-bit unsigned magnitude already holds 2^20,
    // so negating the most-negative dividend needs no wider register here.
    logic [DIVIDEND_W-1:0] dvd_q;
    logic [DIVISOR_W-1:0]  dsr_q;
    logic [DIVISOR_W:0]    prem_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  sign_quot_q;
    logic                  sign_rem_q;
    logic                  dz_pend_q;
    logic                  ovf_pend_q;

    logic [DIVISOR_W+1:0]  shifted;
    logic [DIVISOR_W+1:0]  trial;
    logic                  ge;
    logic [DIVISOR_W:0]    prem_next;
    logic [DIVIDEND_W-1:0] dvd_next;
    logic [DIVIDEND_W-1:0] quot_signed;
    logic [DIVISOR_W:0]    rem_signed;
    logic                  unused_rem_msb;

    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic                  div_zero_q;
    logic                  ovf_q;

    assign last = (cnt_q == LAST_CNT);

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake: new operands are taken in IDLE or in FIN.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ap_start) begin
                    accept  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (bus.ap_start) begin
                    accept  = 1'b1;
                    state_d = S_CALC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The extra top bit of the trial difference is the borrow.
    always_comb begin
        shifted     = {prem_q, dvd_q[DIVIDEND_W-1]};
        trial       = shifted - {2'b00, dsr_q};
        ge          = ~trial[DIVISOR_W+1];
        prem_next   = ge ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
        dvd_next    = {dvd_q[DIVIDEND_W-2:0], ge};
        quot_signed = sign_quot_q ? ('0 - dvd_next) : dvd_next;
        rem_signed  = sign_rem_q ? ('0 - prem_next) : prem_next;
    end

    // |rem| < |divisor| <= 2^13, so the sign-adjusted remainder's top bit is
    // always a copy of bit 13 and is dropped.
    assign unused_rem_msb = rem_signed[DIVISOR_W];

    // Operand capture on accept, then one quotient bit per CALC cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dvd_q       <= '0;
            dsr_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            sign_quot_q <= 1'b0;
            sign_rem_q  <= 1'b0;
            dz_pend_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
        end else if (accept) begin
            dvd_q       <= bus.din0[DIVIDEND_W-1] ? ('0 - bus.din0) : bus.din0;
            dsr_q       <= bus.din1[DIVISOR_W-1] ? ('0 - bus.din1) : bus.din1;
            prem_q      <= '0;
            cnt_q       <= '0;
            sign_quot_q <= bus.din0[DIVIDEND_W-1] ^ bus.din1[DIVISOR_W-1];
            sign_rem_q  <= bus.din0[DIVIDEND_W-1];
            dz_pend_q   <= (bus.din1 == '0);
            ovf_pend_q  <= (bus.din0 == DVD_MIN) && (bus.din1 == '1);
        end else if (state_q == S_CALC) begin
            dvd_q  <= dvd_next;
            prem_q <= prem_next;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Result registers, loaded on the last CALC step so they are valid in FIN
    // and hold until the next operation finishes.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if ((state_q == S_CALC) && last) begin
            quot_q     <= dz_pend_q ? '1 : quot_signed;
            rem_q      <= dz_pend_q ? '0 : rem_signed[DIVISOR_W-1:0];
            div_zero_q <= dz_pend_q;
            ovf_q      <= ovf_pend_q;
        end
    end

    assign bus.ap_ready = accept;
    assign bus.ap_idle  = (state_q == S_IDLE);
    assign bus.ap_done  = (state_q == S_FIN);
    assign bus.quot     = quot_q;
    assign bus.rem      = rem_q;
    assign bus.div_zero = div_zero_q;
    assign bus.ovf      = ovf_q;
    assign state_dbg    = state_q;
endmodule
